// File: rtl/approx_error_monitor.sv
// approx_error_monitor: windowed error statistics for an accurate/approximate
// result pair. A window of 2^LOG_N accepted samples is pushed through a
// three-stage pipeline: difference, then magnitude/square, then accumulation.
// The results are held until the next start.
// Optional feature macro: ERR_SQ_EN. When it is defined, the squared-error
// multiplier and accumulator are built. Without it, err_sq_sum is tied to 0.
module approx_error_monitor #(
  parameter int W     = 32,
  parameter int LOG_N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              acc_data,
  input  logic [W-1:0]              apx_data,
  output logic                      stats_valid,
  output logic signed [W+LOG_N:0]   err_sum,
  output logic [2*W+1+LOG_N:0]      err_sq_sum,
  output logic [W-1:0]              max_abs_err,
  output logic [LOG_N:0]            mismatch_cnt
);

  localparam int SUMW = W + 1 + LOG_N;
  localparam int SQW  = 2 * W + 2 + LOG_N;
  localparam logic [LOG_N-1:0] LAST_IDX = {LOG_N{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [LOG_N-1:0]  cnt_r;
  logic              drain_r;
  logic              in_ready_r;
  logic              stats_valid_r;

  logic              accept_s;
  logic              clear_s;
  logic [W:0]        diff_s;

  logic              s1_valid_r;
  logic [W:0]        s1_err_r;
  logic [W-1:0]      abs_s;
  logic              nz_s;

  logic              s2_valid_r;
  logic [W:0]        s2_err_r;
  logic [W-1:0]      s2_abs_r;
  logic              s2_nz_r;

  logic [SUMW-1:0]   err_sum_r;
  logic [W-1:0]      max_abs_r;
  logic [LOG_N:0]    mismatch_r;

  assign accept_s = in_valid & in_ready_r;
  // A start is only meaningful when no window is being collected.
  assign clear_s  = start & ((state_r == IDLE) | (state_r == DONE));
  // Zero-extended subtraction in W+1 bits is exact in two's complement.
  assign diff_s   = {1'b0, apx_data} - {1'b0, acc_data};

  // Window control FSM: sample counting, drain wait and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {LOG_N{1'b0}};
      drain_r       <= 1'b0;
      in_ready_r    <= 1'b0;
      stats_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r       <= ACCUM;
            cnt_r         <= {LOG_N{1'b0}};
            in_ready_r    <= 1'b1;
            stats_valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            cnt_r <= cnt_r + LOG_N'(1'b1);
            if (cnt_r == LAST_IDX) begin
              state_r    <= DRAIN;
              in_ready_r <= 1'b0;
              drain_r    <= 1'b0;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        DRAIN: begin
          // The last sample needs two more edges to reach the accumulators.
          if (drain_r) begin
            state_r       <= DONE;
            drain_r       <= 1'b0;
            stats_valid_r <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= {LOG_N{1'b0}};
          drain_r       <= 1'b0;
          in_ready_r    <= 1'b0;
          stats_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the signed difference of an accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_err_r   <= {(W+1){1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_err_r <= diff_s;
      end else begin
        s1_err_r <= s1_err_r;
      end
    end
  end

  // Magnitude of the stage 1 difference. The most negative value is unreachable, so W bits suffice.
  always_comb begin
    abs_s = s1_err_r[W-1:0];
    if (s1_err_r[W]) begin
      abs_s = ~s1_err_r[W-1:0] + W'(1'b1);
    end else begin
      abs_s = s1_err_r[W-1:0];
    end
  end

  assign nz_s = |s1_err_r;

  // Stage 2: register the magnitude, the mismatch flag and the difference for the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_err_r   <= {(W+1){1'b0}};
      s2_abs_r   <= {W{1'b0}};
      s2_nz_r    <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_err_r   <= s1_err_r;
      s2_abs_r   <= abs_s;
      s2_nz_r    <= nz_s;
    end
  end

  // Stage 3: accumulate the signed sum, the mismatch count and the running maximum.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      err_sum_r  <= {SUMW{1'b0}};
      max_abs_r  <= {W{1'b0}};
      mismatch_r <= {(LOG_N+1){1'b0}};
    end else if (s2_valid_r) begin
      err_sum_r  <= err_sum_r + {{LOG_N{s2_err_r[W]}}, s2_err_r};
      mismatch_r <= mismatch_r + {{LOG_N{1'b0}}, s2_nz_r};
      if (s2_abs_r > max_abs_r) begin
        max_abs_r <= s2_abs_r;
      end else begin
        max_abs_r <= max_abs_r;
      end
    end else begin
      err_sum_r  <= err_sum_r;
      max_abs_r  <= max_abs_r;
      mismatch_r <= mismatch_r;
    end
  end

`ifdef ERR_SQ_EN
  logic [2*W+1:0] sq_s;
  logic [2*W+1:0] s2_sq_r;
  logic [SQW-1:0] err_sq_r;

  assign sq_s = {{(W+2){1'b0}}, abs_s} * {{(W+2){1'b0}}, abs_s};

  // Stage 2 square register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sq_r <= {(2*W+2){1'b0}};
    end else begin
      s2_sq_r <= sq_s;
    end
  end

  // Stage 3 squared-error accumulator.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      err_sq_r <= {SQW{1'b0}};
    end else if (s2_valid_r) begin
      err_sq_r <= err_sq_r + {{LOG_N{1'b0}}, s2_sq_r};
    end else begin
      err_sq_r <= err_sq_r;
    end
  end

  assign err_sq_sum = err_sq_r;
`else
  assign err_sq_sum = {SQW{1'b0}};
`endif

  assign in_ready     = in_ready_r;
  assign stats_valid  = stats_valid_r;
  assign err_sum      = err_sum_r;
  assign max_abs_err  = max_abs_r;
  assign mismatch_cnt = mismatch_r;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Self-checking bench for approx_error_monitor (W=16, LOG_N=2).
// It uses table-driven windows with hand-computed expectations, a hand-written
// reset/start-ignore sequence, and randomized windows checked against a plain
// arithmetic model.
module tb_approx_error_monitor;

  localparam int W     = 16;
  localparam int LOG_N = 2;
  localparam int NS    = 4;
`ifdef ERR_SQ_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [W-1:0]          acc_data = '0;
  logic [W-1:0]          apx_data = '0;
  logic                  stats_valid;
  logic signed [W+LOG_N:0] err_sum;
  logic [2*W+1+LOG_N:0]  err_sq_sum;
  logic [W-1:0]          max_abs_err;
  logic [LOG_N:0]        mismatch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int win_acc [NS];
  int win_apx [NS];

  typedef struct packed {
    logic [3:0][15:0] acc;
    logic [3:0][15:0] apx;
    int               gap;
    longint           e_sum;
    longint           e_sq;
    int               e_max;
    int               e_mis;
  } vec_t;

  vec_t tbl [6];

  approx_error_monitor #(.W(W), .LOG_N(LOG_N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .acc_data(acc_data), .apx_data(apx_data), .stats_valid(stats_valid),
    .err_sum(err_sum), .err_sq_sum(err_sq_sum), .max_abs_err(max_abs_err),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference statistics computed directly from the sample list.
  task automatic model_window(output longint s, output longint sq, output int mx, output int mis);
    longint d;
    s = 0; sq = 0; mx = 0; mis = 0;
    for (int i = 0; i < NS; i++) begin
      d = longint'(win_apx[i]) - longint'(win_acc[i]);
      s += d;
      sq += d * d;
      if (d < 0) d = -d;
      if (int'(d) > mx) mx = int'(d);
      if (d != 0) mis++;
    end
  endtask

  // Runs one window from IDLE or DONE and checks the clear, the latency and the results.
  task automatic run_window(input string tag, input int gap, input bit rand_start,
                            input longint e_sum, input longint e_sq, input int e_max, input int e_mis);
    int waited;
    logic [31:0] r;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".ready_after_start"}, in_ready, 1);
    check({tag, ".valid_after_start"}, stats_valid, 0);
    check({tag, ".sum_cleared"}, err_sum, 0);
    check({tag, ".sq_cleared"}, err_sq_sum, 0);
    check({tag, ".max_cleared"}, max_abs_err, 0);
    check({tag, ".mis_cleared"}, mismatch_cnt, 0);
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      acc_data = 16'(win_acc[i]);
      apx_data = 16'(win_apx[i]);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      in_valid = 1'b0;
      start = 1'b0;
      r = $urandom;
      acc_data = r[15:0];
      apx_data = r[31:16];
      if (i < NS - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
          step();
          start = 1'b0;
        end
      end
    end
    check({tag, ".ready_in_drain"}, in_ready, 0);
    waited = 0;
    while (!stats_valid && waited < 10) begin
      step();
      waited++;
    end
    check({tag, ".latency"}, waited, 2);
    check({tag, ".err_sum"}, longint'(err_sum), e_sum);
    check({tag, ".err_sq_sum"}, longint'(err_sq_sum), SQ_EN ? e_sq : 64'sd0);
    check({tag, ".max_abs_err"}, max_abs_err, e_max);
    check({tag, ".mismatch_cnt"}, mismatch_cnt, e_mis);
    step();
    step();
    check({tag, ".valid_held"}, stats_valid, 1);
    check({tag, ".sum_frozen"}, longint'(err_sum), e_sum);
    check({tag, ".ready_in_done"}, in_ready, 0);
  endtask

  initial begin
    longint ms, msq;
    int mmx, mmis, mode, gap;

    tbl[0] = '{acc: {16'd1234, 16'd1234, 16'd1234, 16'd1234}, apx: {16'd1234, 16'd1234, 16'd1234, 16'd1234},
               gap: 0, e_sum: 0, e_sq: 0, e_max: 0, e_mis: 0};
    tbl[1] = '{acc: {16'd103, 16'd102, 16'd101, 16'd100}, apx: {16'd106, 16'd105, 16'd104, 16'd103},
               gap: 0, e_sum: 12, e_sq: 36, e_max: 3, e_mis: 4};
    tbl[2] = '{acc: {16'd1000, 16'd1000, 16'd1000, 16'd1000}, apx: {16'd998, 16'd1002, 16'd995, 16'd1005},
               gap: 2, e_sum: 0, e_sq: 58, e_max: 5, e_mis: 4};
    tbl[3] = '{acc: {16'd1000, 16'd1000, 16'd1000, 16'd1000}, apx: {16'd998, 16'd1002, 16'd995, 16'd1005},
               gap: 0, e_sum: 0, e_sq: 58, e_max: 5, e_mis: 4};
    tbl[4] = '{acc: {16'd0, 16'd0, 16'd0, 16'd0}, apx: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
               gap: 0, e_sum: 262140, e_sq: 64'd17179344900, e_max: 65535, e_mis: 4};
    tbl[5] = '{acc: {16'hFFFF, 16'd7, 16'hFFFF, 16'd500}, apx: {16'd0, 16'd7, 16'd0, 16'd499},
               gap: 1, e_sum: -131071, e_sq: 64'd8589672451, e_max: 65535, e_mis: 3};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst.in_ready", in_ready, 0);
    check("rst.stats_valid", stats_valid, 0);
    check("rst.err_sum", err_sum, 0);
    check("rst.err_sq_sum", err_sq_sum, 0);
    check("rst.max_abs_err", max_abs_err, 0);
    check("rst.mismatch_cnt", mismatch_cnt, 0);
    rst = 1'b0;
    step();
    check("idle.in_ready", in_ready, 0);

    // Table-driven windows with hand-computed expectations.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) begin
        win_acc[i] = int'(tbl[r].acc[i]);
        win_apx[i] = int'(tbl[r].apx[i]);
      end
      run_window($sformatf("tbl%0d", r), tbl[r].gap, 1'b0,
                 tbl[r].e_sum, tbl[r].e_sq, tbl[r].e_max, tbl[r].e_mis);
    end

    // Start ignored in ACCUM, then reset mid-window with start in the same cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    acc_data = 16'd10;
    apx_data = 16'd17;
    step();
    step();
    in_valid = 1'b0;
    check("seq.sum_before_first", err_sum, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("seq.sum_first_visible", err_sum, 7);
    check("seq.ready_start_ignored", in_ready, 1);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("seq.rst_in_ready", in_ready, 0);
    check("seq.rst_err_sum", err_sum, 0);
    check("seq.rst_sq", err_sq_sum, 0);
    check("seq.rst_max", max_abs_err, 0);
    check("seq.rst_mis", mismatch_cnt, 0);
    check("seq.rst_valid", stats_valid, 0);
    step();
    step();
    check("seq.idle_after_rst", in_ready, 0);
    check("seq.no_stale_sample", err_sum, 0);

    // Randomized windows against the arithmetic model, with gaps and stray starts.
    for (int w = 0; w < 40; w++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < NS; i++) begin
        case (mode)
          0: begin win_acc[i] = $urandom_range(0, 65535); win_apx[i] = win_acc[i]; end
          1: begin win_acc[i] = $urandom_range(20, 65500); win_apx[i] = win_acc[i] + $urandom_range(0, 20) - 10; end
          2: begin win_acc[i] = $urandom_range(0, 65535); win_apx[i] = $urandom_range(0, 65535); end
          default: begin
            win_acc[i] = $urandom_range(0, 1) * 65535;
            win_apx[i] = $urandom_range(0, 1) * 65535;
          end
        endcase
      end
      gap = $urandom_range(0, 3);
      model_window(ms, msq, mmx, mmis);
      run_window($sformatf("rnd%0d", w), gap, 1'b1, ms, msq, mmx, mmis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
